issue_queue_param: RTL and testbench
====================================

Name: issue_queue_param

Overview:
- Parametrised out-of-order issue queue, successor to the fixed 64-entry, 3-ALU unified queue.
- Sits between dispatch/rename and the functional units.
- Holds renamed micro-ops and wakes operands from NUM_WB writeback broadcast buses.
- Selects the oldest ready entry per functional unit and issues up to NUM_FU ops per cycle, with flush, backpressure and occupancy count.

Parameters:
- DEPTH, 16, number of entries (power of 2, >=2).
- NUM_FU, 3, functional units = issue ports.
- NUM_WB, 2, writeback/wakeup broadcast buses.
- TAG_W, 6, physical register tag width.
- DATA_W, 32, operand/PC/immediate width.
- OP_W, 4, decoded op-type width.
- ROB_W, 6, ROB index width.
- FU_W, $clog2(NUM_FU) (min 1), FU index width (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all entries.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  queue can accept; high when count < DEPTH.
- disp_pc  in  DATA_W  instruction PC.
- disp_op  in  OP_W  decoded op type.
- disp_fu  in  FU_W  target FU index (< NUM_FU).
- disp_src1_tag, disp_src2_tag  in  TAG_W  source physical tags.
- disp_src1_rdy, disp_src2_rdy  in  1  operand already available.
- disp_src1_data, disp_src2_data  in  DATA_W  operand values, valid when rdy.
- disp_imm  in  DATA_W  immediate.
- disp_dest  in  TAG_W  destination physical tag.
- disp_rob  in  ROB_W  ROB index.
- wb_valid  in  NUM_WB  broadcast valid per bus.
- wb_tag  in  NUM_WB*TAG_W  broadcast tags, bus b at [b*TAG_W +: TAG_W].
- wb_data  in  NUM_WB*DATA_W  broadcast values.
- fu_ready  in  NUM_FU  FU f can accept an op this cycle.
- iss_valid  out  NUM_FU  issue pulse per FU.
- iss_pc, iss_src1, iss_src2, iss_imm  out  NUM_FU*DATA_W  issued payload, slot f.
- iss_op  out  NUM_FU*OP_W  issued op type.
- iss_dest  out  NUM_FU*TAG_W  issued destination tag.
- iss_rob  out  NUM_FU*ROB_W  issued ROB index.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, rstn low): all entries invalid, age matrix cleared, count=0, iss_valid=0, all iss_* payloads 0, disp_ready=1.
- Reset mid-operation discards all entries and any in-flight issue outputs.
- disp_ready is derived from registered count only; it does not depend on same-cycle issues.
- Accept = disp_valid & disp_ready. The entry is written into the lowest-index free slot at the edge. It becomes selectable in the following cycle.
- Dispatch-cycle capture: if disp_srcN_rdy=0 and any wb_valid[b] with wb_tag[b]==disp_srcN_tag in the same cycle, store the operand as ready with wb_data[b].
- Wakeup: each edge, every valid entry with srcN not ready and a matching wb bus sets srcN ready and latches data. On multiple matching buses, the lowest bus index wins. Ready entries ignore broadcasts.
- Age: DEPTH x DEPTH age matrix. On allocation the new entry is marked younger than all valid entries. Age is unaffected by wakeup.
- Select, per FU f at each edge: if fu_ready[f], pick the oldest valid entry with fu==f and both sources ready.
  - Drive slot f of iss_* with that entry's fields and set iss_valid[f]=1 for exactly one cycle.
  - Free the entry at the same edge.
  - Otherwise iss_valid[f]=0 and the slot f payload holds its previous value.
- Latency without bypass: operand woken at edge N, entry selected at edge N+1, iss_valid high in cycle after N+1.
- Count: count_next = count + accepted - popcount(issued). Simultaneous dispatch and issue when full: disp_ready is still 0 that cycle. The freed slot is usable next cycle.
- Flush (synchronous, highest priority):
  - Clears all valid bits, count=0 and iss_valid=0 at the edge.
  - Dispatch and wakeup that cycle are ignored.
  - Payload outputs are unchanged.
- Freed slots have their valid bit cleared only; stale fields are never observable.
- Illegal disp_fu (>= NUM_FU): entry is accepted but never issued. Simulation-only assertion flags it.

Optional Feature:
- Macro IQ_WAKEUP_BYPASS_EN.
- Defined: a stored entry whose last missing operand matches a wb bus in cycle N is treated as ready for select at edge N. The issued operand takes wb_data directly, so iss_valid is high one cycle earlier (back-to-back wakeup). Applies to stored entries only; a newly dispatched entry is still selectable next cycle.
- Undefined: wakeup and select are strictly sequential as described in Behaviour.

Test Plan:
- Reset: hold rstn=0 with disp_valid=1 -> count=0, iss_valid=000, disp_ready=1. After release, dispatch one op (fu=1, both rdy, pc=0x40) -> iss_valid=010 with iss_pc slot1=0x40 two cycles after the dispatch edge.
- Full/backpressure: DEPTH=16, fu_ready=0, dispatch 17 ops -> disp_ready falls after 16th accept, count=16. Raise fu_ready[0] for one cycle -> one issue, count=15, disp_ready=1 next cycle.
- Age order: dispatch A(pc=0x10), B(0x14), C(0x18), all fu=0 and ready, fu_ready[0]=1 -> issues in order 0x10, 0x14, 0x18 on consecutive cycles.
- Wakeup: op src2_tag=9 not ready; wb_valid[1]=1, wb_tag=9, wb_data=0xDEAD -> iss_src2=0xDEAD, issue timing per macro setting (one cycle earlier with IQ_WAKEUP_BYPASS_EN).
- Parallel issue: three ready ops for fu 0, 1, 2 with fu_ready=111 -> iss_valid=111 in one cycle, count drops by 3.
- Flush with dispatch and wb same cycle: 5 entries held, assert flush -> count=0, iss_valid=0 next cycle, nothing issued afterward.

Source files
------------

// File: rtl/issue_queue_param.sv
// Parametrised out-of-order issue queue: age-matrix oldest-ready select per FU, NUM_WB wakeup buses.
// Define IQ_WAKEUP_BYPASS_EN to let stored entries issue in the same cycle their last operand wakes.
module issue_queue_param #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_FU = 3,
  parameter int unsigned NUM_WB = 2,
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ROB_W  = 6,
  parameter int unsigned FU_W   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [DATA_W-1:0]          disp_pc,
  input  logic [OP_W-1:0]            disp_op,
  input  logic [FU_W-1:0]            disp_fu,
  input  logic [TAG_W-1:0]           disp_src1_tag,
  input  logic [TAG_W-1:0]           disp_src2_tag,
  input  logic                       disp_src1_rdy,
  input  logic                       disp_src2_rdy,
  input  logic [DATA_W-1:0]          disp_src1_data,
  input  logic [DATA_W-1:0]          disp_src2_data,
  input  logic [DATA_W-1:0]          disp_imm,
  input  logic [TAG_W-1:0]           disp_dest,
  input  logic [ROB_W-1:0]           disp_rob,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic [NUM_WB*DATA_W-1:0]   wb_data,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [NUM_FU-1:0]          iss_valid,
  output logic [NUM_FU*DATA_W-1:0]   iss_pc,
  output logic [NUM_FU*DATA_W-1:0]   iss_src1,
  output logic [NUM_FU*DATA_W-1:0]   iss_src2,
  output logic [NUM_FU*DATA_W-1:0]   iss_imm,
  output logic [NUM_FU*OP_W-1:0]     iss_op,
  output logic [NUM_FU*TAG_W-1:0]    iss_dest,
  output logic [NUM_FU*ROB_W-1:0]    iss_rob,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q, s1_rdy_q, s2_rdy_q;
  // old_q[i][j] set: entry j is older than entry i
  logic [DEPTH-1:0]  old_q [DEPTH];
  logic [DATA_W-1:0] pc_q [DEPTH], imm_q [DEPTH], s1_data_q [DEPTH], s2_data_q [DEPTH];
  logic [OP_W-1:0]   op_q [DEPTH];
  logic [FU_W-1:0]   fu_q [DEPTH];
  logic [TAG_W-1:0]  s1_tag_q [DEPTH], s2_tag_q [DEPTH], dest_q [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [NUM_FU-1:0]        iss_valid_q;
  logic [NUM_FU*DATA_W-1:0] iss_pc_q, iss_src1_q, iss_src2_q, iss_imm_q;
  logic [NUM_FU*OP_W-1:0]   iss_op_q;
  logic [NUM_FU*TAG_W-1:0]  iss_dest_q;
  logic [NUM_FU*ROB_W-1:0]  iss_rob_q;

  logic [DEPTH-1:0]  s1_hit, s2_hit, s1_rdy_eff, s2_rdy_eff, gnt_any;
  logic [DATA_W-1:0] s1_wbd [DEPTH], s2_wbd [DEPTH], s1_data_eff [DEPTH], s2_data_eff [DEPTH];
  logic              d1_rdy, d2_rdy;
  logic [DATA_W-1:0] d1_data, d2_data;
  logic [DEPTH-1:0]  req [NUM_FU];
  logic [IDX_W-1:0]  gnt_idx [NUM_FU];
  logic [NUM_FU-1:0] iss_fire;
  logic [CNT_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  free_idx;
  logic              accept;

  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign accept     = disp_valid && disp_ready;

  // Wakeup match per stored entry and dispatch-cycle capture; lowest bus index wins.
  always_comb begin
    d1_rdy  = disp_src1_rdy;
    d1_data = disp_src1_data;
    d2_rdy  = disp_src2_rdy;
    d2_data = disp_src2_data;
    for (int b = NUM_WB - 1; b >= 0; b--) begin
      if (!disp_src1_rdy && wb_valid[b] && (wb_tag[b*TAG_W +: TAG_W] == disp_src1_tag)) begin
        d1_rdy  = 1'b1;
        d1_data = wb_data[b*DATA_W +: DATA_W];
      end
      if (!disp_src2_rdy && wb_valid[b] && (wb_tag[b*TAG_W +: TAG_W] == disp_src2_tag)) begin
        d2_rdy  = 1'b1;
        d2_data = wb_data[b*DATA_W +: DATA_W];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      s1_hit[i] = 1'b0;
      s2_hit[i] = 1'b0;
      s1_wbd[i] = '0;
      s2_wbd[i] = '0;
      for (int b = NUM_WB - 1; b >= 0; b--) begin
        if (wb_valid[b] && (wb_tag[b*TAG_W +: TAG_W] == s1_tag_q[i])) begin
          s1_hit[i] = 1'b1;
          s1_wbd[i] = wb_data[b*DATA_W +: DATA_W];
        end
        if (wb_valid[b] && (wb_tag[b*TAG_W +: TAG_W] == s2_tag_q[i])) begin
          s2_hit[i] = 1'b1;
          s2_wbd[i] = wb_data[b*DATA_W +: DATA_W];
        end
      end
`ifdef IQ_WAKEUP_BYPASS_EN
      s1_rdy_eff[i]  = s1_rdy_q[i] | s1_hit[i];
      s2_rdy_eff[i]  = s2_rdy_q[i] | s2_hit[i];
      s1_data_eff[i] = s1_rdy_q[i] ? s1_data_q[i] : s1_wbd[i];
      s2_data_eff[i] = s2_rdy_q[i] ? s2_data_q[i] : s2_wbd[i];
`else
      s1_rdy_eff[i]  = s1_rdy_q[i];
      s2_rdy_eff[i]  = s2_rdy_q[i];
      s1_data_eff[i] = s1_data_q[i];
      s2_data_eff[i] = s2_data_q[i];
`endif
    end
  end

  // Oldest-ready select: a requester wins when no other requester is older than it.
  always_comb begin
    gnt_any   = '0;
    iss_fire  = '0;
    issue_cnt = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      req[f]     = '0;
      gnt_idx[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        req[f][i] = valid_q[i] && (fu_q[i] == FU_W'(f)) && s1_rdy_eff[i] && s2_rdy_eff[i] &&
                    fu_ready[f];
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (req[f][i] && ((req[f] & old_q[i]) == '0)) begin
          iss_fire[f] = 1'b1;
          gnt_idx[f]  = IDX_W'(i);
          gnt_any[i]  = 1'b1;
        end
      end
      issue_cnt = issue_cnt + CNT_W'(iss_fire[f]);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      for (int i = 0; i < DEPTH; i++) old_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gnt_any[i]) valid_q[i] <= 1'b0;
        if (valid_q[i] && !s1_rdy_q[i] && s1_hit[i]) s1_rdy_q[i] <= 1'b1;
        if (valid_q[i] && !s2_rdy_q[i] && s2_hit[i]) s2_rdy_q[i] <= 1'b1;
        if (accept) old_q[i][free_idx] <= 1'b0;
      end
      if (accept) begin
        valid_q[free_idx]  <= 1'b1;
        old_q[free_idx]    <= valid_q;
        s1_rdy_q[free_idx] <= d1_rdy;
        s2_rdy_q[free_idx] <= d2_rdy;
      end
    end
  end

  // Entry payload needs no reset: it is only observable through a valid, ready entry.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !s1_rdy_q[i] && s1_hit[i]) s1_data_q[i] <= s1_wbd[i];
        if (valid_q[i] && !s2_rdy_q[i] && s2_hit[i]) s2_data_q[i] <= s2_wbd[i];
      end
      if (accept) begin
        pc_q[free_idx]      <= disp_pc;
        op_q[free_idx]      <= disp_op;
        fu_q[free_idx]      <= disp_fu;
        imm_q[free_idx]     <= disp_imm;
        dest_q[free_idx]    <= disp_dest;
        rob_q[free_idx]     <= disp_rob;
        s1_tag_q[free_idx]  <= disp_src1_tag;
        s2_tag_q[free_idx]  <= disp_src2_tag;
        s1_data_q[free_idx] <= d1_data;
        s2_data_q[free_idx] <= d2_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q     <= '0;
      iss_valid_q <= '0;
      iss_pc_q    <= '0;
      iss_src1_q  <= '0;
      iss_src2_q  <= '0;
      iss_imm_q   <= '0;
      iss_op_q    <= '0;
      iss_dest_q  <= '0;
      iss_rob_q   <= '0;
    end else if (flush) begin
      count_q     <= '0;
      iss_valid_q <= '0;
    end else begin
      count_q     <= count_q + {{(CNT_W-1){1'b0}}, accept} - issue_cnt;
      iss_valid_q <= iss_fire;
      for (int f = 0; f < NUM_FU; f++) begin
        if (iss_fire[f]) begin
          iss_pc_q[f*DATA_W +: DATA_W]   <= pc_q[gnt_idx[f]];
          iss_src1_q[f*DATA_W +: DATA_W] <= s1_data_eff[gnt_idx[f]];
          iss_src2_q[f*DATA_W +: DATA_W] <= s2_data_eff[gnt_idx[f]];
          iss_imm_q[f*DATA_W +: DATA_W]  <= imm_q[gnt_idx[f]];
          iss_op_q[f*OP_W +: OP_W]       <= op_q[gnt_idx[f]];
          iss_dest_q[f*TAG_W +: TAG_W]   <= dest_q[gnt_idx[f]];
          iss_rob_q[f*ROB_W +: ROB_W]    <= rob_q[gnt_idx[f]];
        end
      end
    end
  end

  assign count     = count_q;
  assign iss_valid = iss_valid_q;
  assign iss_pc    = iss_pc_q;
  assign iss_src1  = iss_src1_q;
  assign iss_src2  = iss_src2_q;
  assign iss_imm   = iss_imm_q;
  assign iss_op    = iss_op_q;
  assign iss_dest  = iss_dest_q;
  assign iss_rob   = iss_rob_q;

`ifndef SYNTHESIS
  // An out-of-range FU index is accepted but can never be selected.
  illegal_fu_a: assert property (@(posedge clk) disable iff (!rstn)
    (accept && !flush) |-> (32'(disp_fu) < NUM_FU));
`endif

endmodule

// File: tb/tb_issue_queue_param.sv
// Scoreboard bench for issue_queue_param: an in-order list model predicts issues, a monitor checks.
module tb_issue_queue_param;
  localparam int DEPTH = 16, NUM_FU = 3, NUM_WB = 2, TAG_W = 6, DATA_W = 32;
  localparam int OP_W = 4, ROB_W = 6, FU_W = 2;

  logic clk = 1'b0, rstn = 1'b0, flush = 1'b0, disp_valid = 1'b0, disp_ready;
  logic [DATA_W-1:0] disp_pc = '0, disp_src1_data = '0, disp_src2_data = '0, disp_imm = '0;
  logic [OP_W-1:0]   disp_op = '0;
  logic [FU_W-1:0]   disp_fu = '0;
  logic [TAG_W-1:0]  disp_src1_tag = '0, disp_src2_tag = '0, disp_dest = '0;
  logic              disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
  logic [ROB_W-1:0]  disp_rob = '0;
  logic [NUM_WB-1:0] wb_valid = '0;
  logic [NUM_WB*TAG_W-1:0]  wb_tag = '0;
  logic [NUM_WB*DATA_W-1:0] wb_data = '0;
  logic [NUM_FU-1:0] fu_ready = '0, iss_valid;
  logic [NUM_FU*DATA_W-1:0] iss_pc, iss_src1, iss_src2, iss_imm;
  logic [NUM_FU*OP_W-1:0]   iss_op;
  logic [NUM_FU*TAG_W-1:0]  iss_dest;
  logic [NUM_FU*ROB_W-1:0]  iss_rob;
  logic [$clog2(DEPTH):0]   count;

  always #5 clk = ~clk;

  issue_queue_param dut (
    .clk(clk), .rstn(rstn), .flush(flush), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_pc(disp_pc), .disp_op(disp_op), .disp_fu(disp_fu),
    .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
    .disp_src1_data(disp_src1_data), .disp_src2_data(disp_src2_data),
    .disp_imm(disp_imm), .disp_dest(disp_dest), .disp_rob(disp_rob),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .fu_ready(fu_ready),
    .iss_valid(iss_valid), .iss_pc(iss_pc), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_imm(iss_imm), .iss_op(iss_op), .iss_dest(iss_dest), .iss_rob(iss_rob), .count(count)
  );

  typedef struct {
    logic [DATA_W-1:0] pc, imm, d1, d2;
    logic [OP_W-1:0]   op;
    logic [FU_W-1:0]   fu;
    logic [TAG_W-1:0]  t1, t2, dest;
    logic              r1, r2;
    logic [ROB_W-1:0]  rob;
  } ent_t;

  typedef struct {
    int                stamp;
    int                fu;
    logic [DATA_W-1:0] pc, s1, s2, imm;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [ROB_W-1:0]  rob;
  } exp_t;

  ent_t mq[$];   // held ops, oldest first
  exp_t sb[$];   // expected issues for the current edge
  int   mcount = 0, edge_n = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic wb_hit(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int b = 0; b < NUM_WB; b++) begin
      if (wb_valid[b] && wb_tag[b*TAG_W +: TAG_W] == t) begin
        d = wb_data[b*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic can_issue(input ent_t e, output logic [DATA_W-1:0] o1, o2);
    logic [DATA_W-1:0] w;
    o1 = e.d1;
    o2 = e.d2;
`ifdef IQ_WAKEUP_BYPASS_EN
    if (!e.r1) begin
      if (!wb_hit(e.t1, w)) return 1'b0;
      o1 = w;
    end
    if (!e.r2) begin
      if (!wb_hit(e.t2, w)) return 1'b0;
      o2 = w;
    end
    return 1'b1;
`else
    w = '0;
    return e.r1 && e.r2 && (w == '0);
`endif
  endfunction

  // Reference model: issue oldest eligible op per FU, then wake, then append the dispatch.
  always @(posedge clk or negedge rstn) begin : model
    int prev;
    logic [DATA_W-1:0] a1, a2;
    ent_t n, t;
    exp_t x;
    if (!rstn) begin
      mq.delete();
      sb.delete();
      mcount = 0;
    end else begin
      edge_n++;
      prev = mcount;
      if (flush) begin
        mq.delete();
      end else begin
        for (int f = 0; f < NUM_FU; f++) begin
          if (fu_ready[f]) begin
            for (int i = 0; i < mq.size(); i++) begin
              if (int'(mq[i].fu) == f && can_issue(mq[i], a1, a2)) begin
                x.stamp = edge_n; x.fu = f; x.pc = mq[i].pc; x.s1 = a1; x.s2 = a2;
                x.imm = mq[i].imm; x.op = mq[i].op; x.dest = mq[i].dest; x.rob = mq[i].rob;
                sb.push_back(x);
                mq.delete(i);
                break;
              end
            end
          end
        end
        for (int i = 0; i < mq.size(); i++) begin
          t = mq[i];
          if (!t.r1 && wb_hit(t.t1, a1)) begin t.r1 = 1'b1; t.d1 = a1; end
          if (!t.r2 && wb_hit(t.t2, a2)) begin t.r2 = 1'b1; t.d2 = a2; end
          mq[i] = t;
        end
        if (disp_valid && prev < DEPTH) begin
          n.pc = disp_pc; n.imm = disp_imm; n.op = disp_op; n.fu = disp_fu;
          n.t1 = disp_src1_tag; n.t2 = disp_src2_tag; n.dest = disp_dest; n.rob = disp_rob;
          n.r1 = disp_src1_rdy; n.d1 = disp_src1_data;
          n.r2 = disp_src2_rdy; n.d2 = disp_src2_data;
          if (!n.r1 && wb_hit(disp_src1_tag, a1)) begin n.r1 = 1'b1; n.d1 = a1; end
          if (!n.r2 && wb_hit(disp_src2_tag, a2)) begin n.r2 = 1'b1; n.d2 = a2; end
          mq.push_back(n);
        end
      end
      mcount = mq.size();
    end
  end

  always @(negedge clk) begin : monitor
    logic [NUM_FU-1:0] expv;
    exp_t e;
    expv = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.stamp != edge_n) chk("issue_timing", 64'(e.stamp), 64'(edge_n));
      else begin
        expv[e.fu] = 1'b1;
        if (iss_valid[e.fu]) begin
          chk("iss_pc",   iss_pc[e.fu*DATA_W +: DATA_W],   e.pc);
          chk("iss_src1", iss_src1[e.fu*DATA_W +: DATA_W], e.s1);
          chk("iss_src2", iss_src2[e.fu*DATA_W +: DATA_W], e.s2);
          chk("iss_imm",  iss_imm[e.fu*DATA_W +: DATA_W],  e.imm);
          chk("iss_op",   iss_op[e.fu*OP_W +: OP_W],       e.op);
          chk("iss_dest", iss_dest[e.fu*TAG_W +: TAG_W],   e.dest);
          chk("iss_rob",  iss_rob[e.fu*ROB_W +: ROB_W],    e.rob);
        end
      end
    end
    chk("iss_valid", iss_valid, expv);
    chk("count", count, 64'(mcount));
    chk("disp_ready", disp_ready, mcount < DEPTH);
  end

  task automatic nx();
    @(negedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [DATA_W-1:0] pc, input int fu, input logic r1,
                          input int t1, input logic r2, input int t2);
    disp_valid = 1'b1; disp_pc = pc; disp_fu = FU_W'(fu);
    disp_src1_rdy = r1; disp_src1_tag = TAG_W'(t1); disp_src1_data = $urandom;
    disp_src2_rdy = r2; disp_src2_tag = TAG_W'(t2); disp_src2_data = $urandom;
    disp_imm = $urandom; disp_op = OP_W'($urandom); disp_dest = TAG_W'($urandom);
    disp_rob = ROB_W'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with a dispatch request pending
    set_disp(32'h99, 0, 1'b1, 0, 1'b1, 0);
    nx(); nx();
    chk("rst_count", count, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_iss_pc", iss_pc, 0);
    chk("rst_iss_src1", iss_src1, 0);
    rstn = 1'b1;
    set_disp(32'h40, 1, 1'b1, 0, 1'b1, 0);
    nx();
    disp_valid = 1'b0; fu_ready = 3'b111;
    nx();
    chk("first_valid", iss_valid, 3'b010);
    chk("first_pc", iss_pc[DATA_W +: DATA_W], 32'h40);

    // fill to capacity with all FUs stalled
    fu_ready = '0;
    for (int i = 0; i < 17; i++) begin
      set_disp($urandom, 0, 1'b1, 0, 1'b1, 0);
      nx();
    end
    chk("full_count", count, 16);
    chk("full_ready", disp_ready, 0);
    disp_valid = 1'b0; fu_ready = 3'b001;
    nx();
    chk("drain1_count", count, 15);
    chk("drain1_ready", disp_ready, 1);
    fu_ready = '0; flush = 1'b1;
    nx();
    flush = 1'b0;

    // age ordering
    set_disp(32'h10, 0, 1'b1, 0, 1'b1, 0); nx();
    set_disp(32'h14, 0, 1'b1, 0, 1'b1, 0); nx();
    set_disp(32'h18, 0, 1'b1, 0, 1'b1, 0); nx();
    disp_valid = 1'b0; fu_ready = 3'b001;
    nx(); chk("age0", iss_pc[DATA_W-1:0], 32'h10);
    nx(); chk("age1", iss_pc[DATA_W-1:0], 32'h14);
    nx(); chk("age2", iss_pc[DATA_W-1:0], 32'h18);

    // wakeup from bus 1
    set_disp(32'h80, 0, 1'b1, 0, 1'b0, 9);
    nx();
    disp_valid = 1'b0;
    wb_valid = 2'b10; wb_tag = {6'd9, 6'd3}; wb_data = {32'hDEAD, 32'h1234};
    nx();
`ifdef IQ_WAKEUP_BYPASS_EN
    chk("wake_valid", iss_valid, 3'b001);
    chk("wake_src2", iss_src2[DATA_W-1:0], 32'hDEAD);
    wb_valid = '0;
    nx();
    chk("wake_after", iss_valid, 3'b000);
`else
    chk("wake_wait", iss_valid, 3'b000);
    wb_valid = '0;
    nx();
    chk("wake_valid", iss_valid, 3'b001);
    chk("wake_src2", iss_src2[DATA_W-1:0], 32'hDEAD);
`endif

    // parallel issue on all three FUs
    fu_ready = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      set_disp(32'h100 + 32'(f), f, 1'b1, 0, 1'b1, 0);
      nx();
    end
    disp_valid = 1'b0;
    chk("par_count_before", count, 3);
    fu_ready = 3'b111;
    nx();
    chk("par_valid", iss_valid, 3'b111);
    chk("par_count_after", count, 0);

    // flush with dispatch and wakeup in the same cycle
    fu_ready = '0;
    for (int i = 0; i < 5; i++) begin
      set_disp($urandom, i % NUM_FU, 1'b0, 5, 1'b1, 0);
      nx();
    end
    chk("fl_count_before", count, 5);
    flush = 1'b1; set_disp($urandom, 0, 1'b1, 0, 1'b1, 0);
    wb_valid = 2'b11; wb_tag = {6'd5, 6'd5}; fu_ready = 3'b111;
    nx();
    flush = 1'b0; disp_valid = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", iss_valid, 0);
    for (int i = 0; i < 3; i++) begin
      nx();
      chk("fl_quiet", iss_valid, 0);
    end
    wb_valid = '0;

    // randomized traffic with occasional flush and one mid-run reset
    for (int c = 0; c < 2000; c++) begin
      set_disp($urandom, $urandom_range(0, NUM_FU - 1), 1'($urandom_range(0, 1)),
               $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      disp_valid = ($urandom_range(0, 3) != 0);
      wb_valid = NUM_WB'($urandom);
      wb_tag = {TAG_W'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 7))};
      wb_data = {$urandom, $urandom};
      fu_ready = NUM_FU'($urandom);
      flush = ($urandom_range(0, 49) == 0);
      if (c == 1000) rstn = 1'b0;
      if (c == 1003) rstn = 1'b1;
      nx();
    end

    // drain: broadcast every tag in use and keep all FUs ready
    flush = 1'b0; disp_valid = 1'b0; fu_ready = 3'b111;
    for (int c = 0; c < 40; c++) begin
      wb_valid = 2'b11;
      wb_tag = {TAG_W'(2 * (c % 4) + 1), TAG_W'(2 * (c % 4))};
      wb_data = {$urandom, $urandom};
      nx();
    end
    wb_valid = '0;
    nx();
    chk("drain_count", count, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
